// File: rtl/wishbone_banked_ram_if.sv
// Pipelined Wishbone slave port bundle for wishbone_banked_ram.
// Signal suffixes are from the slave's point of view.
interface wishbone_banked_ram_if #(
  parameter int ADDR_W     = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_W = DATA_WIDTH / 8;

  logic [ADDR_W-1:0]     wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic                  wb_we_i;
  logic [SEL_W-1:0]      wb_sel_i;
  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic                  wb_ack_o;
  logic                  wb_stall_o;

  modport master (
    output wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_data_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_data_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/wishbone_banked_ram.sv
// Dual-port pipelined Wishbone RAM over NUM_BANKS single-port banks.
// Define WB_RAM_RR_ARB_EN for round-robin collision fairness; otherwise port A always wins.
module wishbone_banked_ram #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  wishbone_banked_ram_if.slave  pA,
  wishbone_banked_ram_if.slave  pB
);
  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(SEL_W);
  localparam int WORD_W = $clog2(BANK_WORDS);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = BANK_W + WORD_W + OFF_W;

  logic              req_a, req_b, collide, b_wins, grant_a, grant_b;
  logic [BANK_W-1:0] bank_a, bank_b;
  logic [WORD_W-1:0] word_a, word_b;

  assign bank_a = pA.wb_addr_i[ADDR_W-1 -: BANK_W];
  assign bank_b = pB.wb_addr_i[ADDR_W-1 -: BANK_W];
  assign word_a = pA.wb_addr_i[OFF_W+WORD_W-1 : OFF_W];
  assign word_b = pB.wb_addr_i[OFF_W+WORD_W-1 : OFF_W];

  if (OFF_W > 0) begin : g_off
    logic unused_byte_off;
    assign unused_byte_off = ^{pA.wb_addr_i[OFF_W-1:0], pB.wb_addr_i[OFF_W-1:0]};
  end

  assign req_a   = pA.wb_cyc_i & pA.wb_stb_i & ~rst;
  assign req_b   = pB.wb_cyc_i & pB.wb_stb_i & ~rst;
  assign collide = req_a & req_b & (bank_a == bank_b);
  assign grant_a = req_a & ~(collide & b_wins);
  assign grant_b = req_b & ~(collide & ~b_wins);

  assign pA.wb_stall_o = rst | (collide & b_wins);
  assign pB.wb_stall_o = rst | (collide & ~b_wins);

`ifdef WB_RAM_RR_ARB_EN
  logic prio_q, prio_d;

  // After a collision the loser owns priority for the next one.
  always_comb begin
    prio_d = prio_q;
    if (collide) prio_d = grant_a;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  assign b_wins = prio_q;
`else
  assign b_wins = 1'b0;
`endif

  logic [NUM_BANKS-1:0]                 bank_en, bank_we;
  logic [NUM_BANKS-1:0][WORD_W-1:0]     bank_word;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata;
  logic [NUM_BANKS-1:0][SEL_W-1:0]      bank_sel;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

  always_comb begin
    bank_en    = '0;
    bank_we    = '0;
    bank_word  = '0;
    bank_wdata = '0;
    bank_sel   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (grant_a && (bank_a == BANK_W'(k))) begin
        bank_en[k]    = 1'b1;
        bank_we[k]    = pA.wb_we_i;
        bank_word[k]  = word_a;
        bank_wdata[k] = pA.wb_data_i;
        bank_sel[k]   = pA.wb_sel_i;
      end else if (grant_b && (bank_b == BANK_W'(k))) begin
        bank_en[k]    = 1'b1;
        bank_we[k]    = pB.wb_we_i;
        bank_word[k]  = word_b;
        bank_wdata[k] = pB.wb_data_i;
        bank_sel[k]   = pB.wb_sel_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (bank_en[g]) begin
        if (bank_we[g]) begin
          for (int l = 0; l < SEL_W; l++) begin
            if (bank_sel[g][l]) mem[bank_word[g]][8*l +: 8] <= bank_wdata[g][8*l +: 8];
          end
        end else begin
          rdata_q <= mem[bank_word[g]];
        end
      end
    end

    assign bank_rdata[g] = rdata_q;
  end

  logic              ack_a_q, ack_a_d, rd_a_q, rd_a_d;
  logic              ack_b_q, ack_b_d, rd_b_q, rd_b_d;
  logic [BANK_W-1:0] bank_a_q, bank_a_d, bank_b_q, bank_b_d;

  always_comb begin
    ack_a_d  = grant_a;
    rd_a_d   = grant_a & ~pA.wb_we_i;
    bank_a_d = grant_a ? bank_a : bank_a_q;
    ack_b_d  = grant_b;
    rd_b_d   = grant_b & ~pB.wb_we_i;
    bank_b_d = grant_b ? bank_b : bank_b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_a_q  <= 1'b0;
      rd_a_q   <= 1'b0;
      bank_a_q <= '0;
      ack_b_q  <= 1'b0;
      rd_b_q   <= 1'b0;
      bank_b_q <= '0;
    end else begin
      ack_a_q  <= ack_a_d;
      rd_a_q   <= rd_a_d;
      bank_a_q <= bank_a_d;
      ack_b_q  <= ack_b_d;
      rd_b_q   <= rd_b_d;
      bank_b_q <= bank_b_d;
    end
  end

  // A pending ack is dropped if the master abandons the cycle or reset arrives.
  assign pA.wb_ack_o  = ack_a_q & pA.wb_cyc_i & ~rst;
  assign pB.wb_ack_o  = ack_b_q & pB.wb_cyc_i & ~rst;
  assign pA.wb_data_o = (pA.wb_ack_o & rd_a_q) ? bank_rdata[bank_a_q] : '0;
  assign pB.wb_data_o = (pB.wb_ack_o & rd_b_q) ? bank_rdata[bank_b_q] : '0;
endmodule
